// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard frame receiver and game-command decoder.
// Optional feature macro: PS2_ARROW_KEYS_EN (adds E0-prefixed arrow-key codes).
module ps2_key_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       keyboard_locker,
    output logic [2:0] keyboard_data
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_t;

    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_prev;
    logic                   clk_s, data_s, fall;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic          locker_q, locker_d;
    logic [2:0]    kdata_q, kdata_d;
    logic [2:0]    code;

    // Translate a key byte into a command code; 0 means unmapped.
    function automatic logic [2:0] map_code(input logic ext, input logic [7:0] b);
        logic [2:0] c;
        c = 3'd0;
        if (!ext) begin
            case (b)
                8'h1D:   c = 3'd1;
                8'h1B:   c = 3'd2;
                8'h1C:   c = 3'd3;
                8'h23:   c = 3'd4;
                8'h3B:   c = 3'd5;
                8'h42:   c = 3'd6;
                8'h29:   c = 3'd7;
                default: c = 3'd0;
            endcase
        end else begin
`ifdef PS2_ARROW_KEYS_EN
            case (b)
                8'h75:   c = 3'd1;
                8'h72:   c = 3'd2;
                8'h6B:   c = 3'd3;
                8'h74:   c = 3'd4;
                default: c = 3'd0;
            endcase
`else
            c = 3'd0;
`endif
        end
        return c;
    endfunction

    // Synchronizers and previous-clock register; idle-high lines preload to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync[0]  <= ps2_clk;
            data_sync[0] <= ps2_data;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                clk_sync[i]  <= clk_sync[i-1];
                data_sync[i] <= data_sync[i-1];
            end
            clk_prev <= clk_s;
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;

    // Frame FSM, timeout, prefix tracking and output strobe next-state.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        timeout_d = timeout_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        locker_d  = 1'b0;
        kdata_d   = kdata_q;
        code      = 3'd0;

        // A stalled partial frame is abandoned along with any pending prefix.
        if (state_q == StIdle || fall) begin
            timeout_d = '0;
        end else if (timeout_q == TimeoutLast) begin
            state_d   = StIdle;
            timeout_d = '0;
            ext_d     = 1'b0;
            brk_d     = 1'b0;
        end else begin
            timeout_d = timeout_q + 1'b1;
        end

        if (fall) begin
            unique case (state_q)
                StIdle: begin
                    if (!data_s) begin
                        state_d   = StData;
                        bit_cnt_d = 3'd0;
                        shift_d   = 8'h00;
                    end
                end
                StData: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    parity_d = data_s;
                    state_d  = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (data_s && (^{shift_q, parity_q})) begin
                        if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else begin
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                            if (!brk_q) begin
                                code = map_code(ext_q, shift_q);
                                if (code != 3'd0 && !locker_q) begin
                                    locker_d = 1'b1;
                                    kdata_d  = code;
                                end
                            end
                        end
                    end else begin
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            parity_q  <= 1'b0;
            timeout_q <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            locker_q  <= 1'b0;
            kdata_q   <= 3'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            timeout_q <= timeout_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            locker_q  <= locker_d;
            kdata_q   <= kdata_d;
        end
    end

    assign keyboard_locker = locker_q;
    assign keyboard_data   = kdata_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames, checks strobes.
module tb_ps2_key_decoder;

    localparam int TO = 100;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic       keyboard_locker;
    logic [2:0] keyboard_data;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int strobes = 0;
    int consec  = 0;
    int strobe_cyc = 0;
    int stop_cyc   = 0;
    logic [2:0] last_data = 3'd0;
    logic prev_lock = 1'b0;
    int s0;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(SS)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ps2_clk         (ps2_clk),
        .ps2_data        (ps2_data),
        .keyboard_locker (keyboard_locker),
        .keyboard_data   (keyboard_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (keyboard_locker) begin
            strobes    <= strobes + 1;
            last_data  <= keyboard_data;
            strobe_cyc <= cyc;
            if (prev_lock) consec <= consec + 1;
        end
        prev_lock <= keyboard_locker;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Send the first n bits of an 11-bit frame (start, 8 data LSB-first, parity, stop).
    task automatic send_bits(input logic [7:0] b, input bit good_par, input int n);
        logic [10:0] f;
        logic        par;
        par = good_par ? ~(^b) : (^b);
        f   = {1'b1, par, b, 1'b0};
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ps2_data = f[i];
            repeat (5) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (10) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (5) @(negedge clk);
        end
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_bits(b, 1'b1, 11);
    endtask

    initial begin
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_locker", int'(keyboard_locker), 0);
        check("reset_data", int'(keyboard_data), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // W make code: single strobe, code 1, fixed latency after stop edge.
        s0 = strobes;
        send_frame(8'h1D);
        check("w_count", strobes - s0, 1);
        check("w_data", int'(last_data), 1);
        check("w_latency", strobe_cyc - stop_cyc, SS + 1);
        check("w_hold", int'(keyboard_data), 1);

        // Typematic repeat of W gives another strobe.
        s0 = strobes;
        send_frame(8'h1D);
        check("repeat_count", strobes - s0, 1);

        // Make D, then release D.
        s0 = strobes;
        send_frame(8'h23);
        send_frame(8'hF0);
        send_frame(8'h23);
        check("make_break_count", strobes - s0, 1);
        check("make_break_data", int'(last_data), 4);

        // Bad parity A ignored, then S.
        s0 = strobes;
        send_bits(8'h1C, 1'b0, 11);
        check("bad_parity_count", strobes - s0, 0);
        check("bad_parity_hold", int'(keyboard_data), 4);
        send_frame(8'h1B);
        check("after_bad_count", strobes - s0, 1);
        check("after_bad_data", int'(last_data), 2);

        // Bad frame clears a pending break prefix.
        s0 = strobes;
        send_frame(8'hF0);
        send_bits(8'h55, 1'b0, 11);
        send_frame(8'h23);
        check("break_clear_count", strobes - s0, 1);
        check("break_clear_data", int'(last_data), 4);

        // Unmapped make code leaves output untouched.
        s0 = strobes;
        send_frame(8'h15);
        check("unmapped_count", strobes - s0, 0);
        check("unmapped_hold", int'(keyboard_data), 4);

        // Partial frame abandoned by timeout, then K.
        s0 = strobes;
        send_bits(8'h1D, 1'b1, 4);
        repeat (TO + 10) @(negedge clk);
        send_frame(8'h42);
        check("timeout_count", strobes - s0, 1);
        check("timeout_data", int'(last_data), 6);

        // Extended up-arrow.
        s0 = strobes;
        send_frame(8'hE0);
        send_frame(8'h75);
`ifdef PS2_ARROW_KEYS_EN
        check("arrow_count", strobes - s0, 1);
        check("arrow_data", int'(last_data), 1);
`else
        check("arrow_count", strobes - s0, 0);
        check("arrow_hold", int'(keyboard_data), 6);
`endif

        // Extended prefix never maps a regular make code, and is cleared afterward.
        s0 = strobes;
        send_frame(8'hE0);
        send_frame(8'h1B);
        check("ext_plain_count", strobes - s0, 0);
        send_frame(8'h3B);
        check("ext_cleared_count", strobes - s0, 1);
        check("ext_cleared_data", int'(last_data), 5);

        // Reset in mid-frame, then Space.
        s0 = strobes;
        send_bits(8'h29, 1'b1, 5);
        @(negedge clk) rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_locker", int'(keyboard_locker), 0);
        check("midreset_data", int'(keyboard_data), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h29);
        check("space_count", strobes - s0, 1);
        check("space_data", int'(last_data), 7);

        check("no_back_to_back", consec, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning idle clk cycles between PS/2 falling edges before a partial frame is abandoned.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning flip-flop depth of the ps2_clk/ps2_data synchronizers.
REQ-003 SHALL have port clk  input  1  system clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock from the keyboard.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data from the keyboard.
REQ-007 SHALL have port keyboard_locker  output  1  one-cycle strobe marking a new key event.
REQ-008 SHALL have port keyboard_data  output  3  game command code; valid when keyboard_locker=1 and held until the next event.

Function
REQ-009 SHALL pass ps2_clk and ps2_data through SYNC_STAGES-deep synchronizers before any use.
REQ-010 SHALL detect a falling edge as synchronized ps2_clk going 1->0 and sample synchronized ps2_data in that same cycle.
REQ-011 SHALL run a frame FSM with states IDLE, DATA, PARITY and STOP.
- IDLE->DATA on an edge with data=0 (start bit); a 1 is ignored and the FSM stays in IDLE.
- DATA shifts 8 bits LSB-first via a 3-bit counter, then goes to PARITY after bit 7.
- PARITY->STOP always.
- STOP->IDLE always.
REQ-012 SHALL accept a frame only if data+parity has an odd number of ones and the stop bit is 1; otherwise it discards the frame and clears both prefix flags.
REQ-013 SHALL count clk cycles since the last edge while not in IDLE; when the count reaches TIMEOUT_CYCLES it returns to IDLE, discards the partial frame and clears both prefix flags.
REQ-014 SHALL decode each accepted byte as follows:
- 0xE0 sets ext_pending.
- 0xF0 sets break_pending.
- any other byte is a key byte, after which both flags clear.
REQ-015 SHALL treat a key byte arriving with break_pending=1 as a release: no strobe is issued.
REQ-016 SHALL map non-extended make codes as: 0x1D(W)->1 up, 0x1B(S)->2 down, 0x1C(A)->3 left, 0x23(D)->4 right, 0x3B(J)->5 select, 0x42(K)->6 half-move, 0x29(Space)->7 confirm.
REQ-017 SHALL ignore unmapped make codes: no strobe and keyboard_data unchanged.
REQ-018 SHALL assert keyboard_locker for exactly one cycle, in the cycle after the STOP-bit edge of a mapped make code, with keyboard_data updated in that same cycle.
REQ-019 SHALL produce a new strobe for every typematic repeat of a held key.
REQ-020 SHALL never assert keyboard_locker on two consecutive cycles.

Reset
REQ-021 SHALL, while rst_n=0:
- hold keyboard_locker=0 and keyboard_data=0;
- put the FSM in IDLE;
- clear the bit counter, shift register, timeout counter, ext_pending and break_pending;
- preload the synchronizers with 1.
REQ-022 SHALL, on rst_n asserted mid-frame, drop the partial frame; decoding restarts at the next start bit after release.

Configuration
REQ-023 SHALL, with macro PS2_ARROW_KEYS_EN defined, also map extended (0xE0-prefixed) make codes: 0x75->1, 0x72->2, 0x6B->3, 0x74->4.
REQ-024 SHALL, without PS2_ARROW_KEYS_EN, ignore any key byte that follows 0xE0: no strobe, flags cleared.
REQ-025 SHALL leave non-extended mappings identical in both builds.

Verification
REQ-026 Frame 0x1D with parity 1 and stop 1 -> one-cycle keyboard_locker=1 with keyboard_data=1, one cycle after the stop edge.
REQ-027 Sequence 0x23, 0xF0, 0x23 -> exactly one strobe with data=4; no strobe on the release.
REQ-028 0x1C sent with a wrong parity bit -> no strobe; a following valid 0x1B -> strobe with data=2.
REQ-029 Four bits of a frame, then a gap of TIMEOUT_CYCLES+1 cycles, then a full 0x42 frame -> single strobe with data=6.
REQ-030 0xE0, 0x75 -> strobe with data=1 when PS2_ARROW_KEYS_EN is defined; no strobe when it is undefined.
REQ-031 rst_n pulled low after 5 bits of 0x29, then a full 0x29 frame -> exactly one strobe with data=7, and outputs equal 0 during reset.
